// File: rtl/pipe_ctrl_unit.sv
// Pipeline controller for the 5-stage MIPS datapath: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall, EX branch flush, EX forwarding selects and stall/flush counters.
// Define PIPE_CTRL_JUMP_EN to decode j (op 2) in ID; otherwise op 2 is an unknown opcode.
module pipe_ctrl_unit #(
  parameter int ALUOP_W = 3,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         id_op,
  input  logic [5:0]         id_func,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               ex_zero,
  output logic               id_sgnzero,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               mem_write,
  output logic               wb_regwrite,
  output logic               wb_mem2reg,
  output logic [RA_W-1:0]    wb_dst,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(3'd5);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'd6);
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(3'd7);

  logic               d_regwrite, d_memwrite, d_memread, d_mem2reg;
  logic               d_branch, d_bne, d_alu_src, d_uses_rt;
  logic [ALUOP_W-1:0] d_alu_op;
  logic [RA_W-1:0]    d_dst;

  logic               ex_regwrite, ex_memwrite, ex_memread, ex_mem2reg, ex_branch, ex_bne;
  logic [RA_W-1:0]    ex_dst, ex_rs, ex_rt;
  logic               mem_regwrite, mem_mem2reg;
  logic [RA_W-1:0]    mem_dst;

  logic load_use, taken, stall, jump_fire, id_bubble;

  assign id_sgnzero = !(id_op inside {6'd12, 6'd13, 6'd14});

  always_comb begin
    d_regwrite = 1'b0;
    d_memwrite = 1'b0;
    d_memread  = 1'b0;
    d_mem2reg  = 1'b0;
    d_branch   = 1'b0;
    d_bne      = 1'b0;
    d_alu_src  = 1'b0;
    d_uses_rt  = 1'b0;
    d_alu_op   = ALU_ADD;
    d_dst      = '0;
    case (id_op)
      6'd0: begin
        d_uses_rt = 1'b1;
        if (id_func inside {[6'd32:6'd39], 6'd42, 6'd43}) begin
          d_regwrite = 1'b1;
          d_alu_op   = ALU_RTYPE;
          d_dst      = id_rd;
        end
      end
      6'd4, 6'd5: begin
        d_branch  = 1'b1;
        d_bne     = id_op[0];
        d_uses_rt = 1'b1;
        d_alu_op  = ALU_SUB;
      end
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14: begin
        d_regwrite = 1'b1;
        d_alu_src  = 1'b1;
        d_dst      = id_rt;
        case (id_op)
          6'd10:   d_alu_op = ALU_SLT;
          6'd11:   d_alu_op = ALU_SLTU;
          6'd12:   d_alu_op = ALU_AND;
          6'd13:   d_alu_op = ALU_OR;
          6'd14:   d_alu_op = ALU_XOR;
          default: d_alu_op = ALU_ADD;
        endcase
      end
      6'd35: begin
        d_regwrite = 1'b1;
        d_memread  = 1'b1;
        d_mem2reg  = 1'b1;
        d_alu_src  = 1'b1;
        d_dst      = id_rt;
      end
      6'd43: begin
        d_memwrite = 1'b1;
        d_alu_src  = 1'b1;
        d_uses_rt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every hazard term so a stall or flush in progress is dropped in the reset cycle.
  assign load_use = !rst && ex_memread && (ex_dst != '0) &&
                    ((ex_dst == id_rs) || (d_uses_rt && (ex_dst == id_rt)));
  assign taken    = !rst && ex_branch && (ex_bne ? !ex_zero : ex_zero);
  assign stall    = load_use && !taken;
  assign id_bubble = load_use || taken;

  // A j held in ID behind a load-use stall fires on the cycle after the stall clears.
`ifdef PIPE_CTRL_JUMP_EN
  assign jump_fire = !rst && (id_op == 6'd2) && !taken && !load_use;
  assign pc_src    = taken ? 2'b01 : (jump_fire ? 2'b10 : 2'b00);
`else
  assign jump_fire = 1'b0;
  assign pc_src    = {1'b0, taken};
`endif

  assign pc_en      = !stall;
  assign ifid_en    = !stall;
  assign ifid_flush = taken || jump_fire;

  always_ff @(posedge clk) begin
    if (rst || id_bubble) begin
      ex_regwrite <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_mem2reg  <= 1'b0;
      ex_branch   <= 1'b0;
      ex_bne      <= 1'b0;
      ex_alu_op   <= '0;
      ex_alu_src  <= 1'b0;
      ex_dst      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
    end else begin
      ex_regwrite <= d_regwrite;
      ex_memwrite <= d_memwrite;
      ex_memread  <= d_memread;
      ex_mem2reg  <= d_mem2reg;
      ex_branch   <= d_branch;
      ex_bne      <= d_bne;
      ex_alu_op   <= d_alu_op;
      ex_alu_src  <= d_alu_src;
      ex_dst      <= d_dst;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_regwrite <= 1'b0;
      mem_write    <= 1'b0;
      mem_mem2reg  <= 1'b0;
      mem_dst      <= '0;
      wb_regwrite  <= 1'b0;
      wb_mem2reg   <= 1'b0;
      wb_dst       <= '0;
    end else begin
      mem_regwrite <= ex_regwrite;
      mem_write    <= ex_memwrite;
      mem_mem2reg  <= ex_mem2reg;
      mem_dst      <= ex_dst;
      wb_regwrite  <= mem_regwrite;
      wb_mem2reg   <= mem_mem2reg;
      wb_dst       <= mem_dst;
    end
  end

  // EX/MEM is the younger producer, so it is checked first; $0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_rs))     fwd_a = 2'b10;
      else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_rs))   fwd_a = 2'b01;
      if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_rt))     fwd_b = 2'b10;
      else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_rt))   fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((taken || jump_fire) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed vector table, hand sequences for saturation, jump and
// reset-during-stall, then random instruction streams against a queue-style pipeline model.
module tb_pipe_ctrl_unit;
  localparam int RA_W    = 5;
  localparam int ALUOP_W = 3;
  localparam int CNT_W   = 16;
`ifdef PIPE_CTRL_JUMP_EN
  localparam bit JUMP = 1'b1;
`else
  localparam bit JUMP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [5:0]         id_op, id_func;
  logic [RA_W-1:0]    id_rs, id_rt, id_rd;
  logic               ex_zero;
  logic               id_sgnzero, pc_en, ifid_en, ifid_flush;
  logic [1:0]         pc_src, fwd_a, fwd_b;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_alu_src, mem_write, wb_regwrite, wb_mem2reg;
  logic [RA_W-1:0]    wb_dst;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;

  logic               s_sgnzero, s_pc_en, s_ifid_en, s_ifid_flush;
  logic [1:0]         s_pc_src, s_fwd_a, s_fwd_b;
  logic [ALUOP_W-1:0] s_alu_op;
  logic               s_alu_src, s_mem_write, s_regwrite, s_mem2reg;
  logic [RA_W-1:0]    s_dst;
  logic [1:0]         s_stall_cnt, s_flush_cnt;

  pipe_ctrl_unit #(.ALUOP_W(ALUOP_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_op(id_op), .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .id_sgnzero(id_sgnzero), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .pc_src(pc_src), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .mem_write(mem_write), .wb_regwrite(wb_regwrite),
    .wb_mem2reg(wb_mem2reg), .wb_dst(wb_dst), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_unit #(.ALUOP_W(ALUOP_W), .RA_W(RA_W), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_op(id_op), .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .ex_zero(ex_zero), .id_sgnzero(s_sgnzero), .pc_en(s_pc_en),
    .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .pc_src(s_pc_src), .ex_alu_op(s_alu_op),
    .ex_alu_src(s_alu_src), .mem_write(s_mem_write), .wb_regwrite(s_regwrite),
    .wb_mem2reg(s_mem2reg), .wb_dst(s_dst), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one decoded record per in-flight instruction, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic       rw, mw, mr, m2r, br, bne, src;
    logic [2:0] aop;
    logic [4:0] dst, rs, rt;
  } bundle_t;

  bundle_t pipe [3];
  int m_sc, m_fc;

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit uses_rt(logic [5:0] op);
    return op inside {6'd0, 6'd4, 6'd5, 6'd43};
  endfunction

  function automatic bundle_t ref_decode(logic [5:0] op, logic [5:0] fn,
                                         logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    bundle_t b;
    b = '0;
    b.rs = rs;
    b.rt = rt;
    case (op)
      6'd0:  if (fn inside {6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43}) begin
               b.rw = 1'b1; b.dst = rd; b.aop = 3'd2;
             end
      6'd4:  begin b.br = 1'b1; b.aop = 3'd1; end
      6'd5:  begin b.br = 1'b1; b.bne = 1'b1; b.aop = 3'd1; end
      6'd8, 6'd9: begin b.rw = 1'b1; b.src = 1'b1; b.dst = rt; b.aop = 3'd0; end
      6'd10: begin b.rw = 1'b1; b.src = 1'b1; b.dst = rt; b.aop = 3'd6; end
      6'd11: begin b.rw = 1'b1; b.src = 1'b1; b.dst = rt; b.aop = 3'd7; end
      6'd12: begin b.rw = 1'b1; b.src = 1'b1; b.dst = rt; b.aop = 3'd3; end
      6'd13: begin b.rw = 1'b1; b.src = 1'b1; b.dst = rt; b.aop = 3'd4; end
      6'd14: begin b.rw = 1'b1; b.src = 1'b1; b.dst = rt; b.aop = 3'd5; end
      6'd35: begin b.rw = 1'b1; b.mr = 1'b1; b.m2r = 1'b1; b.src = 1'b1; b.dst = rt; end
      6'd43: begin b.mw = 1'b1; b.src = 1'b1; end
      default: ;
    endcase
    return b;
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] src);
    if (rst || src == 5'd0) return 2'b00;
    if (pipe[1].rw && pipe[1].dst == src) return 2'b10;
    if (pipe[2].rw && pipe[2].dst == src) return 2'b01;
    return 2'b00;
  endfunction

  // {hazard, taken, jump} for the current inputs and model state.
  function automatic logic [2:0] ref_flags();
    logic hz, tk, jf;
    hz = !rst && pipe[0].mr && pipe[0].dst != 5'd0 &&
         (pipe[0].dst == id_rs || (uses_rt(id_op) && pipe[0].dst == id_rt));
    tk = !rst && pipe[0].br && (pipe[0].bne ? !ex_zero : ex_zero);
    jf = JUMP && !rst && id_op == 6'd2 && !tk && !hz;
    return {hz, tk, jf};
  endfunction

  function automatic logic [63:0] ref_expected();
    logic [2:0] f;
    logic       stalled;
    logic [1:0] ps;
    f = ref_flags();
    stalled = f[2] && !f[1];
    ps = f[1] ? 2'b01 : (f[0] ? 2'b10 : 2'b00);
    return {6'b0, !stalled, !stalled, f[1] || f[0], ps, pipe[0].aop, pipe[0].src, pipe[1].mw,
            pipe[2].rw, pipe[2].m2r, pipe[2].dst, ref_fwd(pipe[0].rs), ref_fwd(pipe[0].rt),
            16'(m_sc), 16'(m_fc), !(id_op inside {6'd12, 6'd13, 6'd14}),
            2'(sat(m_sc, 3)), 2'(sat(m_fc, 3))};
  endfunction

  function automatic logic [63:0] dut_actual();
    return {6'b0, pc_en, ifid_en, ifid_flush, pc_src, ex_alu_op, ex_alu_src, mem_write,
            wb_regwrite, wb_mem2reg, wb_dst, fwd_a, fwd_b, stall_cnt, flush_cnt, id_sgnzero,
            s_stall_cnt, s_flush_cnt};
  endfunction

  task automatic modelAdvance();
    logic [2:0] f;
    f = ref_flags();
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      m_sc = sat(m_sc + int'(f[2] && !f[1]), 65535);
      m_fc = sat(m_fc + int'(f[1] || f[0]), 65535);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (f[2] || f[1]) ? '0 : ref_decode(id_op, id_func, id_rs, id_rt, id_rd);
    end
  endtask

  task automatic tick();
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int r, input int op, input int fn, input int rs,
                               input int rt, input int rd, input int z);
    rst     = 1'(r);
    id_op   = 6'(op);
    id_func = 6'(fn);
    id_rs   = 5'(rs);
    id_rt   = 5'(rt);
    id_rd   = 5'(rd);
    ex_zero = 1'(z);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  typedef struct {
    int r, op, fn, rs, rt, rd, z;
    logic       pe, ie, fl, wrw, sg;
    logic [1:0] ps, fa, fb;
    logic [4:0] wdst;
    logic [15:0] sc, fc;
  } vec_t;

  function automatic vec_t mk(int r, int op, int fn, int rs, int rt, int rd, int z,
                              int pe, int ie, int fl, int ps, int fa, int fb,
                              int wrw, int wdst, int sc, int fc, int sg);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.rd = rd; v.z = z;
    v.pe = 1'(pe); v.ie = 1'(ie); v.fl = 1'(fl); v.ps = 2'(ps); v.fa = 2'(fa); v.fb = 2'(fb);
    v.wrw = 1'(wrw); v.wdst = 5'(wdst); v.sc = 16'(sc); v.fc = 16'(fc); v.sg = 1'(sg);
    return v;
  endfunction

  vec_t tbl [23];

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    int ops [19];
    int fns [13];
    ops = '{0, 0, 0, 0, 2, 4, 5, 8, 9, 10, 11, 12, 13, 14, 35, 35, 43, 6, 63};
    fns = '{0, 32, 33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43};

    //                 r  op fn rs rt rd z   pe ie fl ps fa fb wrw wdst sc fc sg
    tbl[0]  = mk(1,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0,  0, 32, 1, 2, 3, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0,  0, 34, 3, 3, 4, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2, 2, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    tbl[5]  = mk(0,  0, 32, 1, 2, 3, 0,  1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1);
    tbl[6]  = mk(0,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0,  0, 34, 3, 3, 4, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 1, 1, 3, 0, 0, 1);
    tbl[9]  = mk(0,  0, 32, 1, 2, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0,  0, 34, 0, 0, 4, 0,  1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1);
    tbl[11] = mk(0,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 35, 0, 1, 5, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[13] = mk(0,  0, 32, 5, 2, 6, 0,  0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1);
    tbl[14] = mk(0,  0, 32, 5, 2, 6, 0,  1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[15] = mk(0,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1, 5, 1, 0, 1);
    tbl[16] = mk(0,  4, 0, 1, 2, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[17] = mk(0,  0, 0, 0, 0, 0, 1,   1, 1, 1, 1, 0, 0, 1, 6, 1, 0, 1);
    tbl[18] = mk(0,  0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[19] = mk(0,  5, 0, 1, 2, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[20] = mk(0,  0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[21] = mk(0, 13, 0, 1, 7, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[22] = mk(0,  0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);

    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_sc = 0;
    m_fc = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    for (int i = 0; i < 23; i++) begin
      applyStimulus(tbl[i].r, tbl[i].op, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].z);
      @(negedge clk);
      checkOutput($sformatf("row%0d", i),
        64'({pc_en, ifid_en, ifid_flush, pc_src, fwd_a, fwd_b, wb_regwrite, wb_dst,
             stall_cnt, flush_cnt, id_sgnzero}),
        64'({tbl[i].pe, tbl[i].ie, tbl[i].fl, tbl[i].ps, tbl[i].fa, tbl[i].fb, tbl[i].wrw,
             tbl[i].wdst, tbl[i].sc, tbl[i].fc, tbl[i].sg}));
      tick();
    end

    // Five more load-use stalls: the 2-bit counter pins at 3 while the wide one keeps counting.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 35, 0, 1, 5, 0, 0);
      @(negedge clk);
      tick();
      applyStimulus(0, 0, 32, 5, 2, 6, 0);
      @(negedge clk);
      checkOutput($sformatf("sat_stall%0d_pc_en", k), 64'({pc_en, ifid_en}), 64'(2'b00));
      tick();
      @(negedge clk);
      checkOutput($sformatf("sat_cnt%0d", k), 64'({stall_cnt, s_stall_cnt}),
                  64'({16'(1 + k), 2'(sat(1 + k, 3))}));
      tick();
    end

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 2, 0, 3, 4, 0, 0);
    @(negedge clk);
    checkOutput("op2_in_id", 64'({pc_src, ifid_flush, pc_en}),
                JUMP ? 64'(4'b1011) : 64'(4'b0001));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("op2_bubble", 64'({ex_alu_op, ex_alu_src, flush_cnt}),
                64'({3'd0, 1'b0, 16'(JUMP ? 1 : 0)}));
    tick();
    applyStimulus(0, 4, 0, 1, 2, 0, 0);
    @(negedge clk);
    tick();
    applyStimulus(0, 2, 0, 3, 4, 0, 1);
    @(negedge clk);
    checkOutput("branch_over_jump", 64'({pc_src, ifid_flush}), 64'(3'b011));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("branch_over_jump_cnt", 64'({pc_src, flush_cnt}),
                64'({2'b00, 16'(JUMP ? 2 : 1)}));
    tick();

    applyStimulus(0, 35, 0, 1, 5, 0, 0);
    @(negedge clk);
    tick();
    applyStimulus(1, 0, 32, 5, 2, 6, 0);
    @(negedge clk);
    checkOutput("reset_cancels_stall", 64'({pc_en, ifid_en, fwd_a, fwd_b}), 64'(6'b110000));
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("after_reset", 64'({stall_cnt, flush_cnt, s_stall_cnt, wb_regwrite, ex_alu_op}),
                64'(0));
    tick();

    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0) ? 1 : 0,
                    ops[$urandom_range(0, 18)], fns[$urandom_range(0, 12)],
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1));
      @(negedge clk);
      checkOutput($sformatf("rand%0d", n), dut_actual(), ref_expected());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
